// File: rtl/midi_uart_fifo_if.sv
// Host-side bundle of the FIFO'd serial bridge: TX/RX byte handshakes, levels, flags, debug state.
// Handshake: a byte moves on a rising clk edge where valid && ready are both 1; valid never waits on ready.
interface midi_uart_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int FIFO_AW   = 9
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [FIFO_AW:0]     tx_level;
  logic [FIFO_AW:0]     rx_level;
  logic                 tx_idle;
  logic                 rx_overrun;
  logic                 rx_frame_err;
  logic                 clr_err;
  logic [2:0]           tx_state;
  logic [2:0]           rx_state;

  modport master (
    output tx_data, tx_valid, rx_ready, clr_err,
    input  tx_ready, rx_data, rx_valid, tx_level, rx_level,
           tx_idle, rx_overrun, rx_frame_err, tx_state, rx_state
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready, clr_err,
    output tx_ready, rx_data, rx_valid, tx_level, rx_level,
           tx_idle, rx_overrun, rx_frame_err, tx_state, rx_state
  );
endinterface

// File: rtl/midi_uart_fifo.sv
// Full-duplex UART bridge with TX and RX FIFOs, sticky overrun/framing flags and level reporting.
// TX FIFO reads asynchronously so the transmitter can load the head on its pop cycle.
module midi_uart_fifo #(
  parameter int CLK_DIV   = 687,
  parameter int DATA_BITS = 8,
  parameter int FIFO_AW   = 9
) (
  input  logic             clk,
  input  logic             reset,
  midi_uart_fifo_if.slave  bus,
  output logic             txd,
  input  logic             rxd
);
  localparam int              DEPTH    = 1 << FIFO_AW;
  localparam logic [15:0]     DIV_M1   = 16'(CLK_DIV - 1);
  localparam logic [15:0]     HALF_M1  = 16'(CLK_DIV / 2 - 1);
  localparam logic [3:0]      LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_STOP = 3'd3} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3,
                            RX_BREAK = 3'd4} rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [DEPTH];
  logic [FIFO_AW:0]     tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic                 tx_empty, tx_full, tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[FIFO_AW] != tx_rd_q[FIFO_AW]) &&
                    (tx_wr_q[FIFO_AW-1:0] == tx_rd_q[FIFO_AW-1:0]);
  assign tx_push  = bus.tx_valid && !tx_full;
  assign tx_head  = tx_mem[tx_rd_q[FIFO_AW-1:0]];

  always_comb begin
    tx_wr_d = tx_wr_q + (FIFO_AW+1)'(tx_push);
    tx_rd_d = tx_rd_q + (FIFO_AW+1)'(tx_pop);
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[FIFO_AW-1:0]] <= bus.tx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
    end else begin
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t            tx_state_q, tx_state_d;
  logic [15:0]          tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 txd_q, txd_d, tx_idle_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      tx_idle_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      tx_idle_q  <= tx_empty && (tx_state_q == TX_IDLE);
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_state_d = TX_START;
          tx_cnt_d   = DIV_M1;
          tx_shift_d = tx_head;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = DIV_M1;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = DIV_M1;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == LAST_BIT) tx_state_d = TX_STOP;
          else                      tx_bit_d   = tx_bit_q + 4'd1;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          // Chain straight into the next start bit so back-to-back frames have no gap.
          if (!tx_empty) begin
            tx_state_d = TX_START;
            tx_cnt_d   = DIV_M1;
            tx_shift_d = tx_head;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_pop = 1'b0;
    txd_d  = 1'b1;
    case (tx_state_q)
      TX_IDLE:  tx_pop = !tx_empty;
      TX_START: txd_d  = 1'b0;
      TX_DATA:  txd_d  = tx_shift_q[0];
      TX_STOP:  tx_pop = (tx_cnt_q == '0) && !tx_empty;
      default:  txd_d  = 1'b1;
    endcase
  end

  // ---------------- RX FSM ----------------
  logic                 rx_sync1_q, rx_sync2_q, rx_prev_q, rx_s;
  rx_state_t            rx_state_q, rx_state_d;
  logic [15:0]          rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_push_q, rx_push_d, rx_ferr_set;
  logic [DATA_BITS-1:0] rx_byte_q;

  assign rx_s = rx_sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_push_q  <= 1'b0;
      rx_byte_q  <= '0;
    end else begin
      rx_sync1_q <= rxd;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_push_q  <= rx_push_d;
      rx_byte_q  <= rx_shift_q;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_M1;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_s) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = DIV_M1;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = DIV_M1;
          rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
          else                      rx_bit_d   = rx_bit_q + 4'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) rx_state_d = rx_s ? RX_IDLE : RX_BREAK;
        else                rx_cnt_d   = rx_cnt_q - 16'd1;
      end
      RX_BREAK: begin
        if (rx_s) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_push_d   = 1'b0;
    rx_ferr_set = 1'b0;
    if (rx_state_q == RX_STOP && rx_cnt_q == '0) begin
      rx_push_d   = rx_s;
      rx_ferr_set = !rx_s;
    end
  end

  // ---------------- RX FIFO (registered show-ahead read) ----------------
  logic [DATA_BITS-1:0] rx_mem [DEPTH];
  logic [FIFO_AW:0]     rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic                 rx_full, rx_pop, rx_wr_en, rx_ovr_set;
  logic                 rx_valid_q, rx_overrun_q, rx_ferr_q;
  logic [DATA_BITS-1:0] rx_data_q;

  assign rx_full    = (rx_wr_q[FIFO_AW] != rx_rd_q[FIFO_AW]) &&
                      (rx_wr_q[FIFO_AW-1:0] == rx_rd_q[FIFO_AW-1:0]);
  assign rx_pop     = rx_valid_q && bus.rx_ready;
  assign rx_wr_en   = rx_push_q && (!rx_full || rx_pop);
  assign rx_ovr_set = rx_push_q && rx_full && !rx_pop;

  always_comb begin
    rx_wr_d = rx_wr_q + (FIFO_AW+1)'(rx_wr_en);
    rx_rd_d = rx_rd_q + (FIFO_AW+1)'(rx_pop);
  end

  always_ff @(posedge clk) begin
    if (rx_wr_en) rx_mem[rx_wr_q[FIFO_AW-1:0]] <= rx_byte_q;
  end

  // An entry written this edge is not readable until the next, hence valid compares the old write pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wr_q      <= '0;
      rx_rd_q      <= '0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_overrun_q <= 1'b0;
      rx_ferr_q    <= 1'b0;
    end else begin
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_valid_q <= (rx_wr_q != rx_rd_d);
      rx_data_q  <= rx_mem[rx_rd_d[FIFO_AW-1:0]];
      if (rx_ovr_set)       rx_overrun_q <= 1'b1;
      else if (bus.clr_err) rx_overrun_q <= 1'b0;
      if (rx_ferr_set)      rx_ferr_q    <= 1'b1;
      else if (bus.clr_err) rx_ferr_q    <= 1'b0;
    end
  end

  assign txd              = txd_q;
  assign bus.tx_ready     = !tx_full;
  assign bus.tx_level     = tx_wr_q - tx_rd_q;
  assign bus.tx_idle      = tx_idle_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_level     = rx_wr_q - rx_rd_q;
  assign bus.rx_overrun   = rx_overrun_q;
  assign bus.rx_frame_err = rx_ferr_q;
  assign bus.tx_state     = tx_state_q;
  assign bus.rx_state     = rx_state_q;
endmodule

// File: tb/tb_midi_uart_fifo.sv
// Directed bench for midi_uart_fifo at CLK_DIV=16, DATA_BITS=8, FIFO_AW=2; txd decoded by an independent monitor.
module tb_midi_uart_fifo;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic txd, rxd;
  logic rxd_drv = 1'b1;
  logic loop_en = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] tx_got_q[$];
  int         tx_start_q[$];
  logic [7:0] rx_got_q[$];
  logic       collect_en = 1'b0;
  int         max_rx_level = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } rx_vec_t;
  rx_vec_t vecs[5];

  midi_uart_fifo_if #(.DATA_BITS(8), .FIFO_AW(2)) bus ();

  midi_uart_fifo #(.CLK_DIV(16), .DATA_BITS(8), .FIFO_AW(2)) dut (
    .clk(clk), .reset(reset), .bus(bus), .txd(txd), .rxd(rxd)
  );

  assign rxd = loop_en ? txd : rxd_drv;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- txd monitor ----------------
  initial begin : tx_mon
    logic [7:0] b;
    int st;
    forever begin
      @(negedge clk);
      if (reset && txd == 1'b0) begin
        st = cyc;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          b[i] = txd;
        end
        repeat (16) @(negedge clk);
        tx_got_q.push_back(b);
        tx_start_q.push_back(st);
      end
    end
  end

  always @(negedge clk) begin
    if (collect_en) begin
      if (bus.rx_valid && bus.rx_ready) rx_got_q.push_back(bus.rx_data);
      if (int'(bus.rx_level) > max_rx_level) max_rx_level = int'(bus.rx_level);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic ok;
    int   guard;
    ok = 1'b0;
    guard = 0;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (!ok && guard < 1000) begin
      ok = bus.tx_ready;
      tick(1);
      guard++;
    end
    bus.tx_valid = 1'b0;
    if (!ok) check("push_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd_drv = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      tick(16);
    end
    rxd_drv = stop;
    tick(16);
    if (!stop) tick(100);
    rxd_drv = 1'b1;
  endtask

  task automatic wait_rx_valid(input string name, input int bound);
    int g;
    g = 0;
    while (!bus.rx_valid && g < bound) begin
      tick(1);
      g++;
    end
    check(name, {31'd0, bus.rx_valid}, 32'd1);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check({name, "_valid"}, {31'd0, bus.rx_valid}, 32'd1);
    check(name, {24'd0, bus.rx_data}, {24'd0, exp});
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
  endtask

  task automatic wait_tx_idle(input int bound);
    int g;
    g = 0;
    while (!bus.tx_idle && g < bound) begin
      tick(1);
      g++;
    end
    check("tx_idle_reached", {31'd0, bus.tx_idle}, 32'd1);
    tick(4);
  endtask

  task automatic check_tx_sb(input string name);
    check({name, "_count"}, tx_got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && tx_got_q.size() > 0)
      check(name, {24'd0, tx_got_q.pop_front()}, {24'd0, exp_q.pop_front()});
    exp_q.delete();
    tx_got_q.delete();
    tx_start_q.delete();
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [9:0] a5_frame;
    vecs[0] = '{data: 8'h3C, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h3C, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h00, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hFF, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h81, exp_ferr: 1'b0};
    vecs[4] = '{data: 8'h3C, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1'b1};
    // start, 1,0,1,0,0,1,0,1, stop -- listed MSB-first so bit k is the k-th bit on the line
    a5_frame = 10'b1_1010_0101_0;

    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    bus.clr_err  = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(2);

    check("rst_txd",      {31'd0, txd},              32'd1);
    check("rst_tx_ready", {31'd0, bus.tx_ready},     32'd1);
    check("rst_tx_idle",  {31'd0, bus.tx_idle},      32'd1);
    check("rst_rx_valid", {31'd0, bus.rx_valid},     32'd0);
    check("rst_rx_data",  {24'd0, bus.rx_data},      32'd0);
    check("rst_tx_level", {29'd0, bus.tx_level},     32'd0);
    check("rst_rx_level", {29'd0, bus.rx_level},     32'd0);
    check("rst_overrun",  {31'd0, bus.rx_overrun},   32'd0);
    check("rst_ferr",     {31'd0, bus.rx_frame_err}, 32'd0);

    // Single loopback byte with bit-accurate txd checks.
    loop_en = 1'b1;
    push_byte(8'hA5);
    exp_q.push_back(8'hA5);
    tick(1);
    check("tx_lat_still_high", {31'd0, txd}, 32'd1);
    tick(1);
    check("tx_lat_start_low", {31'd0, txd}, 32'd0);
    tick(8);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("a5_bit%0d", k), {31'd0, txd}, {31'd0, a5_frame[k]});
      if (k < 9) tick(16);
    end
    wait_rx_valid("a5_rx_valid", 40);
    check("a5_ovr", {31'd0, bus.rx_overrun},   32'd0);
    check("a5_fer", {31'd0, bus.rx_frame_err}, 32'd0);
    pop_check("a5_rx_data", 8'hA5);
    check("a5_rx_empty", {31'd0, bus.rx_valid}, 32'd0);
    wait_tx_idle(100);
    check_tx_sb("a5_tx_sb");
    loop_en = 1'b0;
    tick(20);

    // Table-driven RX frames.
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].data, vecs[v].stop);
      tick(10);
      check($sformatf("vec%0d_valid", v), {31'd0, bus.rx_valid}, {31'd0, vecs[v].exp_valid});
      check($sformatf("vec%0d_ferr", v), {31'd0, bus.rx_frame_err}, {31'd0, vecs[v].exp_ferr});
      check($sformatf("vec%0d_rx_state", v), {29'd0, bus.rx_state}, 32'd0);
      if (vecs[v].exp_valid) pop_check($sformatf("vec%0d_data", v), vecs[v].exp_data);
      check($sformatf("vec%0d_level", v), {29'd0, bus.rx_level}, 32'd0);
      if (vecs[v].exp_ferr) begin
        pulse_clr();
        check($sformatf("vec%0d_ferr_clr", v), {31'd0, bus.rx_frame_err}, 32'd0);
      end
    end

    // Short low glitch: no byte, no error.
    rxd_drv = 1'b0;
    tick(3);
    rxd_drv = 1'b1;
    tick(200);
    check("glitch_valid", {31'd0, bus.rx_valid},     32'd0);
    check("glitch_ferr",  {31'd0, bus.rx_frame_err}, 32'd0);
    check("glitch_level", {29'd0, bus.rx_level},     32'd0);

    // TX fill and back-pressure, frames must be contiguous.
    for (int i = 0; i < 5; i++) begin
      push_byte(8'h61 + 8'(i));
      exp_q.push_back(8'h61 + 8'(i));
    end
    check("fill_tx_level", {29'd0, bus.tx_level}, 32'd4);
    check("fill_tx_ready", {31'd0, bus.tx_ready}, 32'd0);
    check("fill_tx_idle",  {31'd0, bus.tx_idle},  32'd0);
    push_byte(8'h66);
    exp_q.push_back(8'h66);
    wait_tx_idle(1300);
    check("fill_frames", tx_start_q.size(), 32'd6);
    check("fill_span", tx_start_q[5] - tx_start_q[0], 32'd800);
    check_tx_sb("fill_tx_sb");

    // RX overrun with rx_ready low.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      tick(4);
    end
    tick(10);
    check("ovr_level", {29'd0, bus.rx_level},   32'd4);
    check("ovr_flag",  {31'd0, bus.rx_overrun}, 32'd1);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("ovr_drain%0d", i), 8'(i));
    check("ovr_empty", {31'd0, bus.rx_valid}, 32'd0);
    check("ovr_flag_held", {31'd0, bus.rx_overrun}, 32'd1);
    pulse_clr();
    check("ovr_clr", {31'd0, bus.rx_overrun}, 32'd0);

    // Pointer wrap with continuous draining.
    rx_got_q.delete();
    max_rx_level = 0;
    bus.rx_ready = 1'b1;
    collect_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_frame(8'h10 + 8'(i), 1'b1);
      exp_q.push_back(8'h10 + 8'(i));
      tick(2);
    end
    tick(20);
    collect_en = 1'b0;
    bus.rx_ready = 1'b0;
    check("wrap_count", rx_got_q.size(), 32'd10);
    while (exp_q.size() > 0 && rx_got_q.size() > 0)
      check("wrap_order", {24'd0, rx_got_q.pop_front()}, {24'd0, exp_q.pop_front()});
    exp_q.delete();
    check("wrap_max_level", {31'd0, max_rx_level <= 1}, 32'd1);

    // Asynchronous reset during a loopback frame.
    loop_en = 1'b1;
    push_byte(8'hC3);
    push_byte(8'h11);
    push_byte(8'h22);
    tick(16 * 5 + 6);
    #3;
    reset = 1'b0;
    #1;
    check("arst_txd",      {31'd0, txd},          32'd1);
    check("arst_tx_level", {29'd0, bus.tx_level}, 32'd0);
    check("arst_rx_level", {29'd0, bus.rx_level}, 32'd0);
    check("arst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("arst_tx_state", {29'd0, bus.tx_state}, 32'd0);
    check("arst_rx_state", {29'd0, bus.rx_state}, 32'd0);
    tick(3);
    reset = 1'b1;
    tick(200);
    tx_got_q.delete();
    tx_start_q.delete();
    exp_q.delete();
    check("post_rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    push_byte(8'h5A);
    exp_q.push_back(8'h5A);
    wait_rx_valid("post_rst_rx_wait", 220);
    pop_check("post_rst_rx_data", 8'h5A);
    wait_tx_idle(100);
    check_tx_sb("post_rst_tx_sb");
    check("final_ferr", {31'd0, bus.rx_frame_err}, 32'd0);
    check("final_ovr",  {31'd0, bus.rx_overrun},   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
